// File: rtl/instr_encoder_if.sv
// instr_encoder_if: bus bundle for the streaming instruction encoder.
//   Request side : req_valid_i, req_ready_o, req_class_i, rd_i, rs1_i, rs2_i,
//                  funct3_i, funct7_i, imm_i
//   Output side  : instr_valid_o, instr_ready_i, instr_o, addr_o, count_o
//   Status       : error_o (sticky illegal-request flag)
// The slave modport is the encoder; the master modport is the producer/consumer.
interface instr_encoder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_class_i;
  logic [4:0]      rd_i;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [11:0]     imm_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [31:0]     addr_o;
  logic [CntW-1:0] count_o;
  logic            error_o;

  modport slave (
    input  req_valid_i, req_class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  instr_ready_i,
    output req_ready_o, instr_valid_o, instr_o, addr_o, count_o, error_o
  );

  modport master (
    output req_valid_i, req_class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output instr_ready_i,
    input  req_ready_o, instr_valid_o, instr_o, addr_o, count_o, error_o
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I instruction words (R, I-ALU, lw, sw, beq) from
// field-level requests, buffers them in a DEPTH-word circular FIFO and emits
// them with sequential byte addresses starting at BASE_ADDR.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   clear_i : synchronous flush of FIFO and address counter (error flag kept)
//   bus     : instr_encoder_if.slave request/output/status bundle
// Optional feature: define ENCODER_CHECK_EN to reject illegal requests (class 5-7,
// R-type with unsupported funct7) and raise sticky error_o. Without it, classes
// 5-7 encode as NOP and error_o is tied low.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic              clear_i,
  instr_encoder_if.slave   bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_addr;

  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_illegal;
  logic [31:0]     w_word;

  // Handshake flags come from the registered count only.
  assign w_full   = (r_count == CntW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = bus.req_valid_i && !w_full;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = !w_empty && bus.instr_ready_i;

  assign bus.req_ready_o   = !w_full;
  assign bus.instr_valid_o = !w_empty;
  assign bus.instr_o       = r_mem[r_rptr];
  assign bus.addr_o        = r_addr;
  assign bus.count_o       = r_count;

  // Field assembly per instruction class.
  always_comb begin
    w_word    = 32'h0000_0013;
    w_illegal = 1'b0;
    case (bus.req_class_i)
      3'd0: begin
        w_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0110011};
`ifdef ENCODER_CHECK_EN
        w_illegal = (bus.funct7_i != 7'b0000000) && (bus.funct7_i != 7'b0100000);
`endif
      end
      3'd1: w_word = {bus.imm_i, bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0010011};
      3'd2: w_word = {bus.imm_i, bus.rs1_i, 3'b010, bus.rd_i, 7'b0000011};
      3'd3: w_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, 3'b010, bus.imm_i[4:0],
                      7'b0100011};
      // imm_i already holds offset[12:1], so bit n here is offset bit n+1.
      3'd4: w_word = {bus.imm_i[11], bus.imm_i[9:4], bus.rs2_i, bus.rs1_i, 3'b000,
                      bus.imm_i[3:0], bus.imm_i[10], 7'b1100011};
      default: begin
        w_word = 32'h0000_0013;
`ifdef ENCODER_CHECK_EN
        w_illegal = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ENCODER_CHECK_EN
  logic r_error;

  // Sticky until reset; a request accepted during clear_i is discarded entirely.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_error <= 1'b0;
    end else if (!clear_i && w_accept && w_illegal) begin
      r_error <= 1'b1;
    end
  end

  assign bus.error_o = r_error;
`else
  assign bus.error_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_1000;

  logic clk;
  logic rst;
  logic clear;

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  logic        m_err;

`ifdef ENCODER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  // Standard RV32I formats built from the byte-offset view of the immediate.
  function automatic logic [31:0] enc(input int unsigned cls, input int unsigned rd,
                                      input int unsigned rs1, input int unsigned rs2,
                                      input int unsigned f3, input int unsigned f7,
                                      input int unsigned imm);
    int unsigned off;
    case (cls)
      0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      1: return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
      2: return (imm << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      3: return ((imm / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((imm % 32) << 7) | 'h23;
      4: begin
        off = imm * 2;
        return (((off >> 12) & 1) << 31) | (((off >> 5) & 'h3f) << 25) | (rs2 << 20)
               | (rs1 << 15) | (((off >> 1) & 'hf) << 8) | (((off >> 11) & 1) << 7) | 'h63;
      end
      default: return 32'h13;
    endcase
  endfunction

  function automatic bit is_illegal(input int unsigned cls, input int unsigned f7);
    if (!CheckEn) return 1'b0;
    if (cls > 4) return 1'b1;
    return (cls == 0) && (f7 != 0) && (f7 != 32);
  endfunction

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (rst) begin
      mq.delete();
      m_addr = BASE_ADDR;
      m_err  = 1'b0;
    end else if (clear) begin
      mq.delete();
      m_addr = BASE_ADDR;
    end else begin
      do_pop  = (mq.size() > 0) && bus.instr_ready_i;
      do_push = bus.req_valid_i && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (do_push) begin
        if (is_illegal(bus.req_class_i, bus.funct7_i)) m_err = 1'b1;
        else mq.push_back(enc(bus.req_class_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                              bus.funct3_i, bus.funct7_i, bus.imm_i));
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(bus.count_o), mq.size());
      chk("req_ready", 32'(bus.req_ready_o), 32'(mq.size() < DEPTH));
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(mq.size() > 0));
      chk("error", 32'(bus.error_o), 32'(m_err));
      if (mq.size() > 0) begin
        chk("instr", bus.instr_o, mq[0]);
        chk("addr", bus.addr_o, m_addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int unsigned cls, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                      input int unsigned imm);
    bit acc;
    bus.req_valid_i = 1'b1;
    bus.req_class_i = 3'(cls);
    bus.rd_i        = 5'(rd);
    bus.rs1_i       = 5'(rs1);
    bus.rs2_i       = 5'(rs2);
    bus.funct3_i    = 3'(f3);
    bus.funct7_i    = 7'(f7);
    bus.imm_i       = 12'(imm);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = (mq.size() < DEPTH);
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.instr_ready_i = 1'b1;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (mq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", mq.size());
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b1;
    clear             = 1'b0;
    bus.req_valid_i   = 1'b0;
    bus.req_class_i   = '0;
    bus.rd_i          = '0;
    bus.rs1_i         = '0;
    bus.rs2_i         = '0;
    bus.funct3_i      = '0;
    bus.funct7_i      = '0;
    bus.imm_i         = '0;
    bus.instr_ready_i = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    rst = 1'b0;

    // Reset values.
    chk("rst_instr", bus.instr_o, 32'h0);
    chk("rst_addr", bus.addr_o, BASE_ADDR);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_error", 32'(bus.error_o), 32'd0);

    // add x3,x1,x2 visible the cycle after acceptance.
    bus.instr_ready_i = 1'b1;
    send(0, 3, 1, 2, 0, 0, 0);
    chk("add_word", bus.instr_o, 32'h002081B3);
    chk("add_addr", bus.addr_o, BASE_ADDR);
    chk("add_valid", 32'(bus.instr_valid_o), 32'd1);

    // Back-to-back addi / lw / sw / beq while consuming.
    send(1, 1, 0, 0, 0, 0, 12'hFFF);
    chk("addi_word", bus.instr_o, 32'hFFF00093);
    chk("addi_addr", bus.addr_o, BASE_ADDR + 32'd4);
    send(2, 5, 2, 0, 7, 0, 8);
    chk("lw_word", bus.instr_o, 32'h00812283);
    chk("lw_addr", bus.addr_o, BASE_ADDR + 32'd8);
    send(3, 0, 2, 5, 0, 0, 12);
    chk("sw_word", bus.instr_o, 32'h00512623);
    chk("sw_addr", bus.addr_o, BASE_ADDR + 32'd12);
    send(4, 0, 1, 2, 0, 0, 4);
    chk("beq_word", bus.instr_o, 32'h00208463);
    chk("beq_addr", bus.addr_o, BASE_ADDR + 32'd16);
    drain();

    // Fill to DEPTH with the consumer stalled; the extra request waits.
    bus.instr_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < DEPTH + 1; i++) send(0, i + 1, i, 31 - i, i % 8, 32, 0);
      end
      begin
        step(8);
        chk("full_count", 32'(bus.count_o), DEPTH);
        chk("full_ready", 32'(bus.req_ready_o), 32'd0);
        bus.instr_ready_i = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop at count 2.
    bus.instr_ready_i = 1'b0;
    send(1, 4, 3, 0, 6, 0, 12'h123);
    send(2, 5, 2, 0, 0, 0, 8);
    bus.instr_ready_i = 1'b1;
    send(0, 7, 8, 9, 5, 32, 0);
    bus.instr_ready_i = 1'b0;
    chk("pp_count", 32'(bus.count_o), 32'd2);
    chk("pp_head", bus.instr_o, 32'h00812283);
    drain();

    // Clear with three buffered words.
    bus.instr_ready_i = 1'b0;
    send(1, 1, 1, 0, 0, 0, 1);
    send(1, 2, 2, 0, 0, 0, 2);
    send(1, 3, 3, 0, 0, 0, 3);
    chk("pre_clear_count", 32'(bus.count_o), 32'd3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_count", 32'(bus.count_o), 32'd0);
    chk("clear_valid", 32'(bus.instr_valid_o), 32'd0);
    send(0, 3, 1, 2, 0, 0, 0);
    chk("clear_addr", bus.addr_o, BASE_ADDR);
    chk("clear_word", bus.instr_o, 32'h002081B3);
    drain();

    // Illegal class 6.
    bus.instr_ready_i = 1'b0;
    send(6, 1, 2, 3, 4, 5, 6);
`ifdef ENCODER_CHECK_EN
    chk("ill_count", 32'(bus.count_o), 32'd0);
    chk("ill_error", 32'(bus.error_o), 32'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("ill_error_sticky", 32'(bus.error_o), 32'd1);
`else
    chk("ill_word", bus.instr_o, 32'h00000013);
    chk("ill_error", 32'(bus.error_o), 32'd0);
`endif
    drain();

    // Reset mid-stream discards buffered words.
    bus.instr_ready_i = 1'b0;
    send(1, 9, 9, 0, 0, 0, 9);
    send(1, 8, 8, 0, 0, 0, 8);
    bus.instr_ready_i = 1'b1;
    step(1);
    bus.instr_ready_i = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus.count_o), 32'd0);
    chk("mid_rst_addr", bus.addr_o, BASE_ADDR);
    chk("mid_rst_error", 32'(bus.error_o), 32'd0);
    bus.instr_ready_i = 1'b1;
    send(4, 0, 1, 2, 0, 0, 4);
    chk("mid_rst_word", bus.instr_o, 32'h00208463);
    chk("mid_rst_addr2", bus.addr_o, BASE_ADDR);
    drain();
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
